shift_load_ctrl: RTL and testbench

SHIFT_LOAD_CTRL -- requirements
Module: shift_load_ctrl

---
 rtl/shift_ctrl_pkg.sv | 12 +
 rtl/shift_reg_core.sv | 32 +++
 rtl/shift_load_ctrl.sv | 126 ++++++++++++
 tb/tb_shift_load_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared state encoding and default width for the shift/load controller.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SHIFT_WIDTH_DEFAULT = 6;

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit serial-in/parallel-out register; shifts left (new bit into bit 0) by default,
// or right (new bit into the MSB) when SHIFT_LSB_FIRST_EN is defined.
module shift_reg_core
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             w,
  input  logic             sh_en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Serial shift register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (sh_en) begin
`ifdef SHIFT_LSB_FIRST_EN
      r_q <= {w, r_q[WIDTH-1:1]};
`else
      r_q <= {r_q[WIDTH-2:0], w};
`endif
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift_load_ctrl.sv
// Parallel-load / serial-shift controller driving shift_reg_core.
// Bit order is MSB first unless SHIFT_LSB_FIRST_EN is defined.
module shift_load_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic             w,
  output logic             sh_en,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             w_bit;
  logic             w_shift;
  logic             w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Select the holding-register bit addressed by the counter
  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef SHIFT_LSB_FIRST_EN
      w_bit = w_bit | ((r_cnt == CW'(i)) & r_hold[i]);
`else
      w_bit = w_bit | ((r_cnt == CW'(i)) & r_hold[WIDTH-1-i]);
`endif
    end
  end

  // Next-state logic and shift decision
  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next = SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        if (!hold) begin
          w_shift = 1'b1;
          if (w_last) begin
            w_next = DONE;
          end else begin
            w_next = SHIFT;
          end
        end else begin
          w_next = SHIFT;
        end
      end
      DONE: begin
        // Leave only once the consumer has seen a valid q
        if (r_out_valid && out_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, holding word, bit counter and out_valid registers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      // The last bit lands in q on the edge that enters DONE, so flag it one cycle later
      r_out_valid <= (r_state == DONE) && (w_next == DONE);
      if ((r_state == IDLE) && in_valid) begin
        r_hold <= in_data;
        r_cnt  <= '0;
      end else if (w_shift) begin
        r_cnt <= w_last ? '0 : (r_cnt + CW'(1));
      end
    end
  end

  // Output decode
  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state != IDLE);
    out_valid = r_out_valid;
    sh_en     = w_shift;
    if (r_state == SHIFT) begin
      w = w_bit;
    end else begin
      w = 1'b0;
    end
  end

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .clr   (clr),
    .w     (w),
    .sh_en (sh_en),
    .q     (q)
  );

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Self-checking bench for shift_load_ctrl: directed scenarios plus randomized words,
// holds and consumer stalls checked against a transfer-level reference model.
module tb_shift_load_ctrl;

  localparam int W = 6;

  logic         clk       = 1'b0;
  logic         clr       = 1'b1;
  logic [W-1:0] in_data   = '0;
  logic         in_valid  = 1'b0;
  logic         hold      = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         w;
  logic         sh_en;
  logic [W-1:0] q;
  logic         out_valid;
  logic         busy;

  int n_total = 0;
  int n_bad   = 0;

  shift_load_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hold      (hold),
    .w         (w),
    .sh_en     (sh_en),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // k-th bit put on the serial line for word d
  function automatic logic tx_bit(input logic [W-1:0] d, input int k);
`ifdef SHIFT_LSB_FIRST_EN
    return d[k];
`else
    return d[W-1-k];
`endif
  endfunction

  // One complete transfer: accept d, apply hold per hmask bit j in cycle j after accept,
  // stall the consumer rdly cycles, and keep junk on in_data/in_valid while busy.
  task automatic run_word(input logic [W-1:0] d, input logic [31:0] hmask, input int rdly,
                          input logic junk, input logic [W-1:0] junk_data);
    int  ns, nh, nsh, vcyc;
    bit  fin;
    logic exp_sh, exp_w, exp_ov;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_ready act=%b exp=1", in_ready);
    end
    in_data = d; in_valid = 1'b1; hold = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = junk; in_data = junk_data;
    ns = 0; nh = 0; nsh = 0; vcyc = 0; fin = 0;
    for (int j = 0; j < 80 && !fin; j++) begin
      hold   = (j < 32) ? hmask[j] : 1'b0;
      exp_ov = (j >= W + 1 + nh);
      out_ready = exp_ov && (vcyc >= rdly);
      #1;
      exp_sh = (ns < W) && !hold;
      exp_w  = (ns < W) ? tx_bit(d, ns) : 1'b0;
      n_total += 5;
      if (sh_en !== exp_sh) begin n_bad++; $display("FAIL sh_en j=%0d act=%b exp=%b", j, sh_en, exp_sh); end
      if (w !== exp_w) begin n_bad++; $display("FAIL w j=%0d act=%b exp=%b", j, w, exp_w); end
      if (out_valid !== exp_ov) begin n_bad++; $display("FAIL out_valid j=%0d act=%b exp=%b", j, out_valid, exp_ov); end
      if (busy !== 1'b1) begin n_bad++; $display("FAIL busy j=%0d act=%b exp=1", j, busy); end
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready j=%0d act=%b exp=0", j, in_ready); end
      if (sh_en === 1'b1) nsh++;
      if (exp_ov) begin
        n_total++;
        if (q !== d) begin n_bad++; $display("FAIL q_done j=%0d act=%b exp=%b", j, q, d); end
        if (vcyc >= rdly) fin = 1;
        vcyc++;
      end
      if (ns < W) begin
        if (hold) nh++;
        else ns++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; hold = 1'b0; out_ready = 1'b0;
    #1;
    n_total += 4;
    if (!fin) begin n_bad++; $display("FAIL timeout act=no_out_valid exp=out_valid"); end
    if (nsh != W) begin n_bad++; $display("FAIL sh_en_count act=%0d exp=%0d", nsh, W); end
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL back_idle act=ready%b busy%b exp=ready1 busy0", in_ready, busy);
    end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ov_after act=%b exp=0", out_valid); end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    n_total += 5;
    if (q !== '0) begin n_bad++; $display("FAIL rst_q act=%b exp=0", q); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ov act=%b exp=0", out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy act=%b exp=0", busy); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready act=%b exp=1", in_ready); end
    if (sh_en !== 1'b0 || w !== 1'b0) begin n_bad++; $display("FAIL rst_shift act=%b%b exp=00", sh_en, w); end
  endtask

  task automatic test_basic();
`ifdef SHIFT_LSB_FIRST_EN
    run_word(6'b100110, 32'h0, 0, 1'b0, 6'b000000);
`else
    run_word(6'b101101, 32'h0, 0, 1'b0, 6'b000000);
`endif
  endtask

  task automatic test_hold();
    run_word(6'b111111, 32'h0000_000C, 0, 1'b0, 6'b000000);
  endtask

  task automatic test_done_stall();
    run_word(6'b010110, 32'h0, 3, 1'b1, 6'b000001);
  endtask

  task automatic test_clear_mid();
    in_data = 6'b110011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_total++;
      if (sh_en !== 1'b1) begin n_bad++; $display("FAIL clr_pre_shift j=%0d act=%b exp=1", j, sh_en); end
      @(posedge clk); #1;
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    n_total += 3;
    if (q !== '0) begin n_bad++; $display("FAIL clr_q act=%b exp=0", q); end
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL clr_idle act=ready%b busy%b exp=ready1 busy0", in_ready, busy);
    end
    if (sh_en !== 1'b0 || w !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL clr_outs act=%b%b%b exp=000", sh_en, w, out_valid);
    end
    run_word(6'b011010, 32'h0, 1, 1'b0, 6'b000000);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      run_word(W'($urandom), $urandom & $urandom & $urandom, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), W'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_done_stall();
    test_clear_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
